// File: rtl/sample_pkg.sv
// Shared types and width helpers for the sample pipeline collector.
package sample_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} collector_state_t;

  function automatic int unsigned sample_w(int unsigned data_size, int unsigned data_per_sample);
    return data_size * data_per_sample;
  endfunction

  function automatic int unsigned frame_w(int unsigned num_samples, int unsigned smp_w);
    return num_samples * smp_w;
  endfunction

  // A single-slot frame still needs a 1-bit counter.
  function automatic int unsigned cnt_w(int unsigned num_samples);
    return (num_samples > 1) ? $clog2(num_samples) : 1;
  endfunction

endpackage

// File: rtl/sample_collector_if.sv
// Sample/frame handshake bundle between upstream node, collector and frame consumer.
interface sample_collector_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FRAME_W  = 64
);
  logic [SAMPLE_W-1:0] in_sample;
  logic                in_valid;
  logic                in_rec;
  logic [FRAME_W-1:0]  frame_out;
  logic                done;
  logic                ack;

  modport master (
    output in_sample, in_valid, ack,
    input  in_rec, frame_out, done
  );

  modport slave (
    input  in_sample, in_valid, ack,
    output in_rec, frame_out, done
  );
endinterface

// File: rtl/sample_collector_fsm.sv
// Collector control: state, slot counter and in_rec/done/load decode.
module sample_collector_fsm
  import sample_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned CNT_W       = cnt_w(NUM_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic             ack,
  output logic             in_rec,
  output logic             done,
  output logic             load,
  output logic             complete,
  output logic [CNT_W-1:0] slot
);

  collector_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == CNT_W'(NUM_SAMPLES - 1));
  assign slot = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    complete = 1'b0;
    in_rec   = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        in_rec = 1'b1;
        // Completion outranks a simultaneous enable drop; a non-completing
        // transfer during an enable drop is discarded with the partial frame.
        if (in_valid && last) begin
          load     = 1'b1;
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = FULL;
        end else if (!enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (in_valid) begin
          load  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      FULL: begin
        done = 1'b1;
        if (ack) state_d = enable ? COLLECT : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sample_collector.sv
// Terminal sink: packs NUM_SAMPLES samples into one frame, slot 0 first, held until ack.
// Optional running-XOR checksum enabled by SAMPLE_COLLECTOR_CHECKSUM_EN.
module sample_collector
  import sample_pkg::*;
#(
  parameter int unsigned DATA_SIZE       = 4,
  parameter int unsigned DATA_PER_SAMPLE = 4,
  parameter int unsigned NUM_SAMPLES     = 4,
  localparam int unsigned SAMPLE_W = sample_w(DATA_SIZE, DATA_PER_SAMPLE),
  localparam int unsigned FRAME_W  = frame_w(NUM_SAMPLES, SAMPLE_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  sample_collector_if.slave      bus,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [SAMPLE_W-1:0]    checksum
);

  localparam int unsigned CNT_W = cnt_w(NUM_SAMPLES);

  logic             load;
  logic             complete;
  logic [CNT_W-1:0] slot;

  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  sample_collector_fsm #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .CNT_W       (CNT_W)
  ) FSM (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (bus.in_valid),
    .ack      (bus.ack),
    .in_rec   (bus.in_rec),
    .done     (bus.done),
    .load     (load),
    .complete (complete),
    .slot     (slot)
  );

  always_comb begin
    frame_d = frame_q;
    for (int k = 0; k < int'(NUM_SAMPLES); k++) begin
      if (load && (slot == CNT_W'(k))) frame_d[k*SAMPLE_W +: SAMPLE_W] = bus.in_sample;
    end
  end

  assign frame_count_d = complete ? frame_count_q + 1'b1 : frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q       <= '0;
      frame_count_q <= '0;
    end else begin
      frame_q       <= frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.frame_out = frame_q;
  assign frame_count   = frame_count_q;

`ifdef SAMPLE_COLLECTOR_CHECKSUM_EN
  logic [SAMPLE_W-1:0] acc_q, acc_d, chk_q, chk_d;

  // The accumulator sits at zero outside COLLECT, so every entry starts clean.
  always_comb begin
    acc_d = '0;
    chk_d = chk_q;
    if (bus.in_rec) acc_d = load ? (acc_q ^ bus.in_sample) : acc_q;
    if (complete)   chk_d = acc_q ^ bus.in_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      chk_q <= '0;
    end else begin
      acc_q <= acc_d;
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sample_collector.sv
// Self-checking bench for sample_collector: directed scenarios plus randomized frames.
module tb_sample_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] frame_count;
  logic [15:0] checksum;

  sample_collector_if #(.SAMPLE_W(16), .FRAME_W(64)) bus ();

  sample_collector #(
    .DATA_SIZE       (4),
    .DATA_PER_SAMPLE (4),
    .NUM_SAMPLES     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .frame_count (frame_count),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_count = 0;
  logic [15:0] smp [4];
  logic [63:0] held_frame;

  function automatic logic [63:0] exp_frame();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) f[k*16 +: 16] = smp[k];
    return f;
  endfunction

  function automatic logic [15:0] exp_chk();
    logic [15:0] c;
    c = '0;
`ifdef SAMPLE_COLLECTOR_CHECKSUM_EN
    for (int k = 0; k < 4; k++) c = c ^ smp[k];
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample after an idle gap; done must match whether it closed the frame.
  task automatic send(input logic [15:0] s, input int gap, input bit closes);
    int t;
    repeat (gap) begin
      bus.in_valid  = 1'b0;
      bus.in_sample = 16'($urandom);
      bus.ack       = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_done: got %b expected 0", bus.done);
      end
    end
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.ack       = 1'($urandom_range(0, 1));
    t = 0;
    while (bus.in_rec !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (bus.in_rec !== 1'b1) begin
      n_fail++;
      $display("FAIL in_rec_timeout: got %b expected 1", bus.in_rec);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.ack      = 1'b0;
    n_checks++;
    if (bus.done !== closes) begin
      n_fail++;
      $display("FAIL done_after_xfer: got %b expected %b", bus.done, closes);
    end
  endtask

  task automatic collect_frame(input int gap_max);
    for (int i = 0; i < 4; i++) send(smp[i], $urandom_range(0, gap_max), i == 3);
    exp_count++;
    n_checks++;
    if (bus.frame_out !== exp_frame()) begin
      n_fail++;
      $display("FAIL frame_out: got %h expected %h", bus.frame_out, exp_frame());
    end
    n_checks++;
    if (frame_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_count);
    end
    n_checks++;
    if (checksum !== exp_chk()) begin
      n_fail++;
      $display("FAIL checksum: got %h expected %h", checksum, exp_chk());
    end
    n_checks++;
    if (bus.in_rec !== 1'b0) begin
      n_fail++;
      $display("FAIL in_rec_full: got %b expected 0", bus.in_rec);
    end
  endtask

  task automatic do_ack(input bit en);
    enable  = en;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.in_rec !== en) begin
      n_fail++;
      $display("FAIL ack_release: got done=%b in_rec=%b expected done=0 in_rec=%b",
               bus.done, bus.in_rec, en);
    end
  endtask

  task automatic check_zero(input string tag);
    n_checks++;
    if (bus.frame_out !== 64'h0 || bus.done !== 1'b0 || bus.in_rec !== 1'b0 ||
        frame_count !== 16'h0 || checksum !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: got frame=%h done=%b in_rec=%b cnt=%h chk=%h expected all zero",
               tag, bus.frame_out, bus.done, bus.in_rec, frame_count, checksum);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.ack       = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("reset_state");
    tick();
    rst = 1'b0;
    tick();
    check_zero("idle_after_reset");
  endtask

  task automatic test_first_frame();
    enable = 1'b1;
    smp[0] = 16'h0F3A; smp[1] = 16'hCC81; smp[2] = 16'h3A58; smp[3] = 16'h9696;
    collect_frame(0);
    n_checks++;
    if (bus.frame_out !== 64'h96963A58CC810F3A) begin
      n_fail++;
      $display("FAIL first_frame_const: got %h expected 96963a58cc810f3a", bus.frame_out);
    end
  endtask

  task automatic test_hold();
    held_frame    = exp_frame();
    bus.in_valid  = 1'b1;
    repeat (10) begin
      bus.in_sample = 16'($urandom);
      tick();
      n_checks++;
      if (bus.frame_out !== held_frame || bus.done !== 1'b1 || bus.in_rec !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_full: got frame=%h done=%b in_rec=%b expected frame=%h done=1 in_rec=0",
                 bus.frame_out, bus.done, bus.in_rec, held_frame);
      end
    end
    bus.in_valid = 1'b0;
    do_ack(1'b1);
    smp[0] = 16'h1111; smp[1] = 16'h2222; smp[2] = 16'h3333; smp[3] = 16'h4444;
    collect_frame(0);
  endtask

  task automatic test_gaps();
    do_ack(1'b1);
    smp[0] = 16'h0F3A; smp[1] = 16'hCC81; smp[2] = 16'h3A58; smp[3] = 16'h9696;
    for (int i = 0; i < 4; i++) send(smp[i], 2, i == 3);
    exp_count++;
    n_checks++;
    if (bus.frame_out !== 64'h96963A58CC810F3A || frame_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL gap_frame: got frame=%h cnt=%0d expected frame=96963a58cc810f3a cnt=%0d",
               bus.frame_out, frame_count, exp_count);
    end
  endtask

  task automatic test_abort();
    do_ack(1'b1);
    send(16'($urandom), 0, 1'b0);
    send(16'($urandom), 1, 1'b0);
    enable        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'($urandom);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_rec !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got in_rec=%b done=%b expected 0 0", bus.in_rec, bus.done);
    end
    repeat (5) begin
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || frame_count !== 16'(exp_count)) begin
        n_fail++;
        $display("FAIL abort_quiet: got done=%b cnt=%0d expected 0 %0d",
                 bus.done, frame_count, exp_count);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) smp[k] = 16'($urandom);
    collect_frame(1);
  endtask

  task automatic test_enable_drop_on_complete();
    do_ack(1'b1);
    for (int k = 0; k < 4; k++) smp[k] = 16'($urandom);
    for (int i = 0; i < 3; i++) send(smp[i], 0, 1'b0);
    bus.in_sample = smp[3];
    bus.in_valid  = 1'b1;
    enable        = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    exp_count++;
    n_checks++;
    if (bus.done !== 1'b1 || bus.frame_out !== exp_frame() || frame_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL drop_on_complete: got done=%b frame=%h cnt=%0d expected 1 %h %0d",
               bus.done, bus.frame_out, frame_count, exp_frame(), exp_count);
    end
    do_ack(1'b0);
    tick();
    n_checks++;
    if (bus.in_rec !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_to_idle: got in_rec=%b expected 0", bus.in_rec);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(16'($urandom), 0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    for (int k = 0; k < 4; k++) smp[k] = 16'($urandom);
    collect_frame(0);
  endtask

  task automatic test_random();
    repeat (6) begin
      do_ack(1'b1);
      for (int k = 0; k < 4; k++) smp[k] = 16'($urandom);
      collect_frame(3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_hold();
    test_gaps();
    test_abort();
    test_enable_drop_on_complete();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
